// File: rtl/uart_frame_tx_if.sv
// uart_frame_tx_if: snapshot handshake between a channel producer and the frame transmitter
interface uart_frame_tx_if #(parameter int NUM_CH = 32);
  logic [NUM_CH*8-1:0] in_channel_data;
  logic                data_valid;
  logic                data_acknowledge;
  modport master(output in_channel_data, output data_valid, input data_acknowledge);
  modport slave(input in_channel_data, input data_valid, output data_acknowledge);
endinterface

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: sends sync byte, NUM_CH snapshot bytes and a mod-256 checksum as 8N1 UART frames
module uart_frame_tx #(
  parameter int         CLK_FREQ     = 50_000_000,
  parameter int         BAUD         = 115200,
  parameter int         CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int         NUM_CH       = 32,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_frame_tx_if.slave  bus,
  output logic            tx_pin,
  output logic            busy
);
  localparam int         CW   = $clog2(CLKS_PER_BIT);
  localparam logic [5:0] LAST = 6'(NUM_CH + 1);
  localparam logic [5:0] NCH  = 6'(NUM_CH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t              state, state_n;
  logic [NUM_CH*8-1:0] shadow, shadow_n;
  logic [7:0]          shift, shift_n, sum, sum_n;
  logic [5:0]          byte_idx, byte_n;
  logic [2:0]          bit_idx, bit_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic                tx_n, busy_n, ack, ack_n, bit_end;
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  assign bus.data_acknowledge = ack;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shadow   <= '0;
      shift    <= '0;
      sum      <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
      cnt      <= '0;
      tx_pin   <= 1'b1;
      busy     <= 1'b0;
      ack      <= 1'b0;
    end else begin
      state    <= state_n;
      shadow   <= shadow_n;
      shift    <= shift_n;
      sum      <= sum_n;
      byte_idx <= byte_n;
      bit_idx  <= bit_n;
      cnt      <= cnt_n;
      tx_pin   <= tx_n;
      busy     <= busy_n;
      ack      <= ack_n;
    end
  end
  // Line level is registered alongside the state so every bit lasts exactly CLKS_PER_BIT cycles
  always_comb begin
    state_n  = state;
    shadow_n = shadow;
    shift_n  = shift;
    sum_n    = sum;
    byte_n   = byte_idx;
    bit_n    = bit_idx;
    cnt_n    = bit_end ? '0 : cnt + CW'(1);
    tx_n     = tx_pin;
    busy_n   = busy;
    ack_n    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (bus.data_valid) begin
          shadow_n = bus.in_channel_data;
          shift_n  = SYNC_BYTE;
          sum_n    = '0;
          byte_n   = '0;
          ack_n    = 1'b1;
          busy_n   = 1'b1;
          tx_n     = 1'b0;
          state_n  = START;
        end
      end
      START: if (bit_end) begin
        state_n = DATA;
        bit_n   = '0;
        tx_n    = shift[0];
      end
      DATA: if (bit_end) begin
        if (bit_idx == 3'd7) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end else begin
          bit_n   = bit_idx + 3'd1;
          shift_n = shift >> 1;
          tx_n    = shift[1];
        end
      end
      STOP: if (bit_end) begin
        if (byte_idx < LAST) begin
          byte_n   = byte_idx + 6'd1;
          // The shadow drains one channel per byte, so the next channel is always at the bottom
          shift_n  = byte_idx < NCH ? shadow[7:0] : sum;
          sum_n    = byte_idx < NCH ? sum + shadow[7:0] : sum;
          shadow_n = byte_idx < NCH ? shadow >> 8 : shadow;
          tx_n     = 1'b0;
          state_n  = START;
        end else begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
